// File: rtl/fea_step_sequencer.sv
// Host-side controller for the FEA node array: streams node positions and initial
// values onto the shared set_val/command bus, then issues spaced STEP commands.
module fea_step_sequencer #(
    parameter int NUM_NODES = 8,
    parameter int SEL_W     = $clog2(NUM_NODES),
    parameter int STEP_W    = 16,
    parameter int SETTLE    = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [STEP_W-1:0]    num_steps,
    input  logic [31:0]          kval_in,
    input  logic [31:0]          dt_in,
    input  logic                 abort,
    input  logic                 init_valid,
    output logic                 init_ready,
    input  logic [31:0]          init_data,
    output logic [NUM_NODES-1:0] node_sel,
    output logic [2:0]           command,
    output logic [31:0]          set_val,
    output logic [31:0]          kval,
    output logic [31:0]          dt,
    output logic                 busy,
    output logic                 done,
    output logic [STEP_W-1:0]    steps_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_POS,
        S_LOAD_VAL,
        S_SETTLE_INIT,
        S_RUN,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [2:0] CMD_WR_PROTECT = 3'd0;
    localparam logic [2:0] CMD_SET_NODE   = 3'd1;
    localparam logic [2:0] CMD_SET_POS    = 3'd2;
    localparam logic [2:0] CMD_STEP       = 3'd3;

    // A zero settle time still needs one WAIT cycle to do the step bookkeeping.
    localparam int             WAIT_CYCLES = (SETTLE == 0) ? 1 : SETTLE;
    localparam logic [3:0]     WAIT_LAST   = 4'(WAIT_CYCLES - 1);
    localparam logic [SEL_W-1:0] LAST_IDX  = SEL_W'(NUM_NODES - 1);

    state_t            state;
    logic [SEL_W-1:0]  idx;
    logic [3:0]        wait_cnt;
    logic [STEP_W-1:0] steps_target;
    logic [STEP_W-1:0] steps_next;
    logic              beat;

    assign init_ready = (state == S_LOAD_POS) || (state == S_LOAD_VAL);
    assign beat       = init_ready && init_valid;

    // NOTE: a single unconditional assignment keeps this purely combinational (no latch).
    // Saturating increment: steps_done can never pass the programmed count or wrap.
    always_comb begin
        steps_next = (steps_done == steps_target) ? steps_done : steps_done + 1'b1;
    end

    // NOTE: non-blocking assignments throughout, so every branch sees pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            idx          <= '0;
            wait_cnt     <= '0;
            steps_target <= '0;
            steps_done   <= '0;
            command      <= CMD_WR_PROTECT;
            node_sel     <= '0;
            set_val      <= '0;
            kval         <= '0;
            dt           <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            command  <= CMD_WR_PROTECT;
            node_sel <= '0;
            done     <= 1'b0;

            if (abort && (state != S_IDLE)) begin
                state <= S_IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            steps_target <= num_steps;
                            kval         <= kval_in;
                            dt           <= dt_in;
                            steps_done   <= '0;
                            idx          <= '0;
                            busy         <= 1'b1;
                            state        <= S_LOAD_POS;
                        end
                    end

                    S_LOAD_POS, S_LOAD_VAL: begin
                        if (beat) begin
                            command  <= (state == S_LOAD_POS) ? CMD_SET_POS : CMD_SET_NODE;
                            set_val  <= init_data;
                            node_sel <= NUM_NODES'(1) << idx;
                            if (idx == LAST_IDX) begin
                                idx   <= '0;
                                state <= (state == S_LOAD_POS) ? S_LOAD_VAL : S_SETTLE_INIT;
                            end else begin
                                idx <= idx + 1'b1;
                            end
                        end
                    end

                    S_SETTLE_INIT: begin
                        if (steps_target != '0) begin
                            state <= S_RUN;
                        end else begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end
                    end

                    S_RUN: begin
                        command  <= CMD_STEP;
                        node_sel <= '1;
                        wait_cnt <= '0;
                        state    <= S_WAIT;
                    end

                    S_WAIT: begin
                        if (wait_cnt == WAIT_LAST) begin
                            steps_done <= steps_next;
                            if (steps_next == steps_target) begin
                                done  <= 1'b1;
                                state <= S_DONE;
                            end else begin
                                state <= S_RUN;
                            end
                        end else begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end

                    S_DONE: begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end

                    default: begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fea_step_sequencer.sv
// Self-checking bench: random init words and step counts are checked against an
// expected command stream and run-length formula built from the block's rules.
module tb_fea_step_sequencer;

    localparam int N      = 8;
    localparam int SEL_W  = 3;
    localparam int STEP_W = 16;
    localparam int S      = 2;
    localparam int W      = (S == 0) ? 1 : S;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [STEP_W-1:0] num_steps;
    logic [31:0]       kval_in;
    logic [31:0]       dt_in;
    logic              abort;
    logic              init_valid;
    logic              init_ready;
    logic [31:0]       init_data;
    logic [N-1:0]      node_sel;
    logic [2:0]        command;
    logic [31:0]       set_val;
    logic [31:0]       kval;
    logic [31:0]       dt;
    logic              busy;
    logic              done;
    logic [STEP_W-1:0] steps_done;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [2:0]   cmd;
        logic [N-1:0] sel;
        logic [31:0]  val;
    } ev_t;

    ev_t exp_q[$];

    fea_step_sequencer #(
        .NUM_NODES(N),
        .SEL_W    (SEL_W),
        .STEP_W   (STEP_W),
        .SETTLE   (S)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .num_steps (num_steps),
        .kval_in   (kval_in),
        .dt_in     (dt_in),
        .abort     (abort),
        .init_valid(init_valid),
        .init_ready(init_ready),
        .init_data (init_data),
        .node_sel  (node_sel),
        .command   (command),
        .set_val   (set_val),
        .kval      (kval),
        .dt        (dt),
        .busy      (busy),
        .done      (done),
        .steps_done(steps_done)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passed, total);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " command"},    64'(command),    64'(0));
        check({tag, " node_sel"},   64'(node_sel),   64'(0));
        check({tag, " set_val"},    64'(set_val),    64'(0));
        check({tag, " kval"},       64'(kval),       64'(0));
        check({tag, " dt"},         64'(dt),         64'(0));
        check({tag, " init_ready"}, 64'(init_ready), 64'(0));
        check({tag, " busy"},       64'(busy),       64'(0));
        check({tag, " done"},       64'(done),       64'(0));
        check({tag, " steps_done"}, 64'(steps_done), 64'(0));
    endtask

    // One complete run. valid_mode: 0 every cycle, 1 toggling 1,0,1,0, 2 random.
    // abort_at > 0 aborts in the cycle steps_done first reads that value.
    task automatic run_case(input string name, input int n, input int valid_mode,
                            input bit directed, input int abort_at, input int start_mid_cyc);
        logic [31:0] words [2*N];
        logic [31:0] k_exp;
        logic [31:0] dt_exp;
        int          beat_idx;
        int          stalls;
        int          cyc;
        int          total_exp;
        bit          finished;
        ev_t         ev;

        exp_q.delete();
        for (int i = 0; i < 2*N; i++) begin
            if (directed) words[i] = (i < N) ? 32'(i) : 32'(100 + i - N);
            else          words[i] = $urandom;
        end
        for (int i = 0; i < 2*N; i++)
            exp_q.push_back('{cmd: (i < N) ? 3'd2 : 3'd1, sel: N'(1 << (i % N)), val: words[i]});
        for (int i = 0; i < n; i++)
            exp_q.push_back('{cmd: 3'd3, sel: {N{1'b1}}, val: 32'h0});

        k_exp     = $urandom;
        dt_exp    = $urandom;
        start     = 1'b1;
        num_steps = STEP_W'(n);
        kval_in   = k_exp;
        dt_in     = dt_exp;
        @(posedge clk); #1;
        start     = 1'b0;
        kval_in   = $urandom;
        dt_in     = $urandom;
        num_steps = STEP_W'($urandom_range(1, 9));
        check({name, " busy rises"},         64'(busy),       64'(1));
        check({name, " steps_done cleared"}, 64'(steps_done), 64'(0));

        beat_idx = 0;
        stalls   = 0;
        cyc      = 1;
        finished = 1'b0;
        while (!finished) begin
            check({name, " init_ready"}, 64'(init_ready), 64'(beat_idx < 2*N));
            check({name, " kval"},       64'(kval),       64'(k_exp));
            check({name, " dt"},         64'(dt),         64'(dt_exp));
            if (command != 3'd0) begin
                if (exp_q.size() == 0) begin
                    check({name, " extra command"}, 64'(command), 64'(0));
                end else begin
                    ev = exp_q.pop_front();
                    check({name, " command"},  64'(command),  64'(ev.cmd));
                    check({name, " node_sel"}, 64'(node_sel), 64'(ev.sel));
                    if (ev.cmd != 3'd3) check({name, " set_val"}, 64'(set_val), 64'(ev.val));
                end
            end else begin
                check({name, " idle node_sel"}, 64'(node_sel), 64'(0));
            end

            if (done) begin
                total_exp = 2*N + stalls + 1 + n*(1 + W) + 1;
                check({name, " done cycle"},      64'(cyc),          64'(total_exp));
                check({name, " steps_done"},      64'(steps_done),   64'(n));
                check({name, " commands issued"}, 64'(exp_q.size()), 64'(0));
                init_valid = 1'b0;
                @(posedge clk); #1;
                check({name, " done one cycle"},  64'(done),       64'(0));
                check({name, " busy falls"},      64'(busy),       64'(0));
                check({name, " steps_done held"}, 64'(steps_done), 64'(n));
                finished = 1'b1;
            end else if (abort_at > 0 && int'(steps_done) == abort_at) begin
                abort      = 1'b1;
                start      = 1'b1;
                init_valid = 1'b1;
                @(posedge clk); #1;
                abort      = 1'b0;
                start      = 1'b0;
                init_valid = 1'b0;
                check({name, " abort busy"},       64'(busy),         64'(0));
                check({name, " abort command"},    64'(command),      64'(0));
                check({name, " abort node_sel"},   64'(node_sel),     64'(0));
                check({name, " abort steps_done"}, 64'(steps_done),   64'(abort_at));
                check({name, " abort init_ready"}, 64'(init_ready),   64'(0));
                check({name, " abort no step"},    64'(exp_q.size()), 64'(n - abort_at));
                for (int i = 0; i < 4; i++) begin
                    @(posedge clk); #1;
                    check({name, " abort no done"},    64'(done),    64'(0));
                    check({name, " abort quiet bus"},  64'(command), 64'(0));
                end
                check({name, " abort kval held"}, 64'(kval), 64'(k_exp));
                finished = 1'b1;
            end else if (cyc > 2000) begin
                check({name, " timeout waiting for done"}, 64'(done), 64'(1));
                finished = 1'b1;
            end else begin
                start = (cyc == start_mid_cyc);
                if (beat_idx < 2*N) begin
                    case (valid_mode)
                        0:       init_valid = 1'b1;
                        1:       init_valid = (cyc % 2 == 1);
                        default: init_valid = 1'($urandom_range(0, 1));
                    endcase
                    init_data = init_valid ? words[beat_idx] : $urandom;
                    if (init_valid) beat_idx++;
                    else            stalls++;
                end else begin
                    init_valid = 1'($urandom_range(0, 1));
                    init_data  = $urandom;
                end
                @(posedge clk); #1;
                cyc++;
            end
        end
        start      = 1'b0;
        init_valid = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b1;
        num_steps  = 16'd3;
        kval_in    = 32'hdead_beef;
        dt_in      = 32'h1234_5678;
        abort      = 1'b0;
        init_valid = 1'b1;
        init_data  = 32'hffff_ffff;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        reset      = 1'b0;
        init_valid = 1'b0;

        run_case("directed", 3, 0, 1'b1, 0, 20);
        run_case("toggle",   2, 1, 1'b0, 0, 0);
        run_case("zero",     0, 0, 1'b0, 0, 0);
        run_case("abort",    5, 0, 1'b0, 2, 0);
        run_case("reload",   4, 2, 1'b0, 0, 0);
        for (int r = 0; r < 4; r++)
            run_case("random", $urandom_range(0, 6), 2, 1'b0, 0, 0);

        start      = 1'b1;
        num_steps  = 16'd2;
        kval_in    = $urandom;
        dt_in      = $urandom;
        @(posedge clk); #1;
        start      = 1'b0;
        init_valid = 1'b1;
        init_data  = $urandom;
        repeat (5) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check_reset_values("midrun reset");
        @(posedge clk); #1;
        check("midrun reset no pending command", 64'(command), 64'(0));
        reset      = 1'b0;
        init_valid = 1'b0;

        run_case("after reset", 1, 0, 1'b0, 0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fea_step_sequencer.md
# fea_step_sequencer

Controller that initializes and time-steps the 1-D array of `node` cells in the FEA datapath. It loads every node's position and initial value from a host word stream over the shared `set_val`/`command` bus. It then runs a programmed number of explicit time steps, holding `kval`/`dt` stable and spacing steps so the node update path settles. It sits between the host interface and the node array and is the only driver of node commands.

## Interface
- `NUM_NODES`, 8: nodes in the array (2..256).
- `SEL_W`, 3: width of node index, `clog2(NUM_NODES)`.
- `STEP_W`, 16: width of step count.
- `SETTLE`, 2: idle cycles inserted after each STEP command (0..15).

- `clk` input 1: rising-edge clock.
- `reset` input 1: asynchronous, active-high reset.
- `start` input 1: begin a run when in IDLE; sampled every cycle.
- `num_steps` input STEP_W: steps to run; latched on accepted `start`.
- `kval_in`, `dt_in` input 32 each: constants; latched on accepted `start`.
- `abort` input 1: abandon the current run.
- `init_valid` input 1 / `init_ready` output 1: valid/ready handshake for init words.
- `init_data` input 32: init word (positions, then values).
- `node_sel` output NUM_NODES: one-hot write enable per node; all ones during STEP.
- `command` output 3: 0 WR_PROTECT, 1 SET_NODE, 2 SET_POS, 3 STEP.
- `set_val` output 32: data to the selected node.
- `kval`, `dt` output 32 each: latched constants to all nodes.
- `busy` output 1: high in any state other than IDLE.
- `done` output 1: one-cycle pulse at run completion.
- `steps_done` output STEP_W: completed step count for the current or last run.

## Operation
- Reset values: state IDLE; `command`=0; `node_sel`=0; `set_val`=0; `kval`=`dt`=0; `init_ready`=0; `busy`=0; `done`=0; `steps_done`=0.
- IDLE: `start`=1 latches `num_steps`, `kval_in`, `dt_in`, clears `steps_done` and the node index, then moves to LOAD_POS. `start` is ignored outside IDLE.
- LOAD_POS: `init_ready`=1. On each beat (`init_valid`&&`init_ready`), the next cycle presents `command`=SET_POS, `set_val`=`init_data`, and `node_sel` one-hot at the index; the index then increments. After beat NUM_NODES-1 the index clears and the state moves to LOAD_VAL.
- LOAD_VAL: same as LOAD_POS with `command`=SET_NODE. After the last beat, the state moves to SETTLE_INIT.
- SETTLE_INIT: one cycle of WR_PROTECT. Then RUN if the latched `num_steps`≠0, else DONE.
- RUN: one cycle of `command`=STEP with `node_sel` all ones, then WAIT.
- WAIT: SETTLE cycles of WR_PROTECT, then `steps_done`++. If `steps_done`==`num_steps` after the increment, go to DONE, else RUN. With SETTLE=0, WAIT lasts exactly 1 cycle; the increment happens there.
- DONE: `done`=1 for one cycle, then IDLE.
- Outside beat cycles and STEP, `command`=WR_PROTECT and `node_sel`=0. Unused `set_val` holds its last value.
- `abort`: from any non-IDLE state, the next state is IDLE and `command` is forced to WR_PROTECT that same edge. `done` does not pulse, and `steps_done` keeps its partial count. `abort` has priority over `start` and over beats in the same cycle.
- `steps_done` saturates at the latched `num_steps` and never wraps. `num_steps`=2^STEP_W−1 is legal.
- `reset` mid-run returns everything to reset values immediately, with no pending command issued.

## Timing
- Command outputs are registered: a beat accepted at edge N gives `command`/`set_val`/`node_sel` valid for cycle N+1 only.
- `init_ready` is combinational from state only and never depends on `init_valid`.
- Back-to-back beats are accepted every cycle. Stalls on `init_valid`=0 insert WR_PROTECT cycles.
- Run length from `start` accepted to `done`, with zero stall: 2·NUM_NODES + 1 (SETTLE_INIT) + `num_steps`·(1+max(SETTLE,1)) + 1 (DONE) cycles.
- `kval`/`dt` change only on an accepted `start` and are stable for the whole run.

## Test plan
- Reset with `start` held high → all outputs at reset values. First `start` after deassert is accepted and `busy` rises next cycle.
- NUM_NODES=8, 16 consecutive beats with positions 0..7 and values 100..107 → 8 SET_POS cycles then 8 SET_NODE cycles. Index k has `node_sel`=1<<k and the correct `set_val`.
- `init_valid` toggled 1,0,1,0 → WR_PROTECT in each gap, no word lost or duplicated, load ends after exactly 16 accepted beats.
- `num_steps`=3, SETTLE=2 → exactly 3 STEP cycles, each followed by 2 WR_PROTECT cycles. `done` pulses once, `steps_done`=3, total 2·8+1+9+1=27 cycles.
- `num_steps`=0 → no STEP issued, and `done` pulses 2 cycles after the last init beat.
- `abort` during RUN after step 2 of 5 → IDLE next cycle, no `done`, `steps_done`=2. A new `start` reloads cleanly. `start` asserted mid-run is ignored.
